// File: rtl/fb_bram_arbiter.sv
// Frame-buffer BRAM owner: muxes display reads, the fill engine and the pixel writer onto one port.
// Display read data appears exactly 2 cycles after the request; fill and writer grants take effect in the same cycle.
// Display is never stalled; fill stalls while the display requests; the writer's wr_ready is low during a display request or an active fill.
module fb_bram_arbiter #(
    parameter int ROW_W = 7,
    parameter int COL_W = 7,
    parameter int PIX_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   disp_req,
    input  logic [ROW_W-1:0]       disp_row,
    input  logic [COL_W-1:0]       disp_col,
    output logic [PIX_W-1:0]       disp_rgb,
    output logic                   disp_valid,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    input  logic [ROW_W-1:0]       wr_row,
    input  logic [COL_W-1:0]       wr_col,
    input  logic [PIX_W-1:0]       wr_data,
    input  logic                   fill_start,
    input  logic [PIX_W-1:0]       fill_color,
    output logic                   fill_busy,
    output logic                   fill_done,
    output logic [ROW_W+COL_W-1:0] ram_addr,
    output logic                   ram_we,
    output logic [PIX_W-1:0]       ram_wdata,
    input  logic [PIX_W-1:0]       ram_rdata
);

    localparam int ADDR_W = ROW_W + COL_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    typedef enum logic {
        ST_IDLE,
        ST_FILL
    } fill_state_t;

    fill_state_t       state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [PIX_W-1:0]  color_q, color_d;
    logic              done_d;
    logic              fill_we;
    logic              req_d1;

    // A fill is in progress for the whole time the FSM sits in FILL; the
    // cycle that carries fill_done is already back in IDLE.
    assign fill_busy = (state_q == ST_FILL);

    // Writer only gets the port when neither higher-priority user wants it.
    assign wr_ready = wr_valid & ~disp_req & ~fill_busy;

    // Fill FSM next-state: latch colour on start, step the counter on every
    // cycle the display leaves the port free, leave after the last word.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        color_d = color_q;
        done_d  = 1'b0;
        fill_we = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (fill_start) begin
                    state_d = ST_FILL;
                    cnt_d   = '0;
                    color_d = fill_color;
                end
            end
            ST_FILL: begin
                if (!disp_req) begin
                    fill_we = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == LAST_ADDR) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Fill FSM state, counter, latched colour and the done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            color_q   <= '0;
            fill_done <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            color_q   <= color_d;
            fill_done <= done_d;
        end
    end

    // Grant mux: display > fill > writer; idle port drives all zeros.
    always_comb begin
        ram_addr  = '0;
        ram_we    = 1'b0;
        ram_wdata = '0;
        if (disp_req) begin
            ram_addr = {disp_row, disp_col};
        end else if (fill_we) begin
            ram_addr  = cnt_q;
            ram_we    = 1'b1;
            ram_wdata = color_q;
        end else if (wr_ready) begin
            ram_addr  = {wr_row, wr_col};
            ram_we    = 1'b1;
            ram_wdata = wr_data;
        end
    end

    // Read pipeline: request tag follows the BRAM's one-cycle read, then the
    // returned word is registered; disp_rgb holds between valid pixels.
    always_ff @(posedge clk) begin
        if (reset) begin
            req_d1     <= 1'b0;
            disp_valid <= 1'b0;
            disp_rgb   <= '0;
        end else begin
            req_d1     <= disp_req;
            disp_valid <= req_d1;
            if (req_d1) begin
                disp_rgb <= ram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_fb_bram_arbiter.sv
// Directed bench for fb_bram_arbiter with a behavioural single-port BRAM.
// Inputs change 1 ns after the rising edge; outputs are sampled 1 ns later.
// Each task drives one scenario and compares inline against hand-computed values.
module tb_fb_bram_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        disp_req;
    logic [6:0]  disp_row, disp_col;
    logic [15:0] disp_rgb;
    logic        disp_valid;
    logic        wr_valid, wr_ready;
    logic [6:0]  wr_row, wr_col;
    logic [15:0] wr_data;
    logic        fill_start;
    logic [15:0] fill_color;
    logic        fill_busy, fill_done;
    logic [13:0] ram_addr;
    logic        ram_we;
    logic [15:0] ram_wdata;
    logic [15:0] ram_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] mem [0:16383];

    always #5 clk = ~clk;

    // Single-port BRAM, read-first, one cycle read latency.
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    fb_bram_arbiter #(.ROW_W(7), .COL_W(7), .PIX_W(16)) dut (
        .clk(clk), .reset(reset),
        .disp_req(disp_req), .disp_row(disp_row), .disp_col(disp_col),
        .disp_rgb(disp_rgb), .disp_valid(disp_valid),
        .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data),
        .fill_start(fill_start), .fill_color(fill_color),
        .fill_busy(fill_busy), .fill_done(fill_done),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic idle_inputs;
        disp_req = 0; disp_row = 0; disp_col = 0;
        wr_valid = 0; wr_row = 0; wr_col = 0; wr_data = 0;
        fill_start = 0; fill_color = 0;
    endtask

    task automatic wr_push(input logic [6:0] r, input logic [6:0] c, input logic [15:0] d);
        next_cycle;
        wr_valid = 1; wr_row = r; wr_col = c; wr_data = d;
        next_cycle;
        wr_valid = 0;
    endtask

    task automatic disp_read(input logic [6:0] r, input logic [6:0] c,
                             output logic [15:0] d, output logic v);
        next_cycle;
        disp_req = 1; disp_row = r; disp_col = c;
        next_cycle;
        disp_req = 0;
        next_cycle;
        settle;
        v = disp_valid;
        d = disp_rgb;
    endtask

    task automatic test_reset;
        reset = 1;
        idle_inputs();
        repeat (3) next_cycle;
        settle;
        n_checks++; if (disp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_disp_valid got %b exp 0", disp_valid); end
        n_checks++; if (disp_rgb !== 16'h0) begin n_fail++; $display("FAIL reset_disp_rgb got %h exp 0000", disp_rgb); end
        n_checks++; if (fill_busy !== 1'b0) begin n_fail++; $display("FAIL reset_fill_busy got %b exp 0", fill_busy); end
        n_checks++; if (fill_done !== 1'b0) begin n_fail++; $display("FAIL reset_fill_done got %b exp 0", fill_done); end
        n_checks++; if (ram_we !== 1'b0 || ram_addr !== 14'h0 || ram_wdata !== 16'h0) begin
            n_fail++; $display("FAIL reset_no_grant got we=%b addr=%h wdata=%h exp 0/0000/0000", ram_we, ram_addr, ram_wdata);
        end
        next_cycle;
        reset = 0;
    endtask

    task automatic test_display_pipeline;
        logic [15:0] exp_px [4];
        logic        exp_v;
        logic [13:0] exp_a;
        exp_px[0] = 16'h000F; exp_px[1] = 16'h000F; exp_px[2] = 16'h0F00; exp_px[3] = 16'h0F00;
        for (int i = 0; i < 4; i++) wr_push(7'd0, 7'(i), exp_px[i]);
        for (int k = 0; k < 7; k++) begin
            next_cycle;
            disp_req = (k < 4);
            disp_row = 7'd0;
            disp_col = 7'(k);
            settle;
            exp_v = (k >= 2 && k <= 5);
            n_checks++; if (disp_valid !== exp_v) begin n_fail++; $display("FAIL disp_valid_cycle%0d got %b exp %b", k, disp_valid, exp_v); end
            if (k >= 2 && k <= 5) begin
                n_checks++; if (disp_rgb !== exp_px[k-2]) begin n_fail++; $display("FAIL disp_rgb_cycle%0d got %h exp %h", k, disp_rgb, exp_px[k-2]); end
            end
            if (k < 4) begin
                exp_a = 14'(k);
                n_checks++; if (ram_addr !== exp_a || ram_we !== 1'b0) begin
                    n_fail++; $display("FAIL disp_addr_cycle%0d got addr=%h we=%b exp %h/0", k, ram_addr, ram_we, exp_a);
                end
            end
            if (k == 6) begin
                n_checks++; if (disp_rgb !== 16'h0F00) begin n_fail++; $display("FAIL disp_rgb_hold got %h exp 0f00", disp_rgb); end
            end
        end
        disp_req = 0;
    endtask

    task automatic test_writer;
        next_cycle;
        wr_valid = 1; wr_row = 7'd5; wr_col = 7'd7; wr_data = 16'hABCD;
        settle;
        n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL wr_ready_idle got %b exp 1", wr_ready); end
        n_checks++; if (ram_addr !== 14'h0287 || ram_we !== 1'b1 || ram_wdata !== 16'hABCD) begin
            n_fail++; $display("FAIL wr_port got addr=%h we=%b wdata=%h exp 0287/1/abcd", ram_addr, ram_we, ram_wdata);
        end
        next_cycle;
        wr_valid = 0;
        disp_req = 1; disp_row = 7'd5; disp_col = 7'd7;
        next_cycle;
        disp_req = 0;
        next_cycle;
        settle;
        n_checks++; if (disp_valid !== 1'b1 || disp_rgb !== 16'hABCD) begin
            n_fail++; $display("FAIL wr_readback got v=%b rgb=%h exp 1/abcd", disp_valid, disp_rgb);
        end
    endtask

    task automatic test_back_to_back;
        int          writes;
        logic [15:0] d;
        logic        v;
        writes = 0;
        for (int k = 0; k < 4; k++) begin
            next_cycle;
            wr_valid = 1; wr_row = 7'd9; wr_col = 7'd3; wr_data = 16'h5555;
            disp_req = (k < 3); disp_row = 7'd1; disp_col = 7'd1;
            settle;
            n_checks++; if (wr_ready !== (k == 3)) begin n_fail++; $display("FAIL wr_stall_ready_cycle%0d got %b exp %b", k, wr_ready, (k == 3)); end
            if (ram_we) writes++;
        end
        next_cycle;
        wr_valid = 0; disp_req = 0;
        settle;
        if (ram_we) writes++;
        n_checks++; if (writes != 1) begin n_fail++; $display("FAIL wr_stall_write_count got %0d exp 1", writes); end
        disp_read(7'd9, 7'd3, d, v);
        n_checks++; if (v !== 1'b1 || d !== 16'h5555) begin n_fail++; $display("FAIL wr_stall_readback got v=%b rgb=%h exp 1/5555", v, d); end
    endtask

    task automatic test_fill;
        int          busy_cycles, done_cnt, ready_viol;
        logic        finished;
        logic [15:0] d;
        logic        v;
        logic [6:0]  rr [4];
        logic [6:0]  cc [4];
        busy_cycles = 0; done_cnt = 0; ready_viol = 0; finished = 0;
        rr[0] = 7'd0;   cc[0] = 7'd0;
        rr[1] = 7'd63;  cc[1] = 7'd127;
        rr[2] = 7'd127; cc[2] = 7'd127;
        rr[3] = 7'd2;   cc[3] = 7'd2;
        next_cycle;
        fill_start = 1; fill_color = 16'h1234;
        wr_valid = 1; wr_row = 7'd2; wr_col = 7'd2; wr_data = 16'hBEEF;
        settle;
        n_checks++; if (wr_ready !== 1'b1 || ram_addr !== 14'h0102 || ram_wdata !== 16'hBEEF) begin
            n_fail++; $display("FAIL fill_start_writer got ready=%b addr=%h wdata=%h exp 1/0102/beef", wr_ready, ram_addr, ram_wdata);
        end
        next_cycle;
        fill_start = 0; fill_color = 16'hFFFF;
        for (int i = 0; i < 20000 && !finished; i++) begin
            wr_valid = fill_busy;
            settle;
            if (i == 0) begin
                n_checks++; if (ram_addr !== 14'h0 || ram_we !== 1'b1 || ram_wdata !== 16'h1234) begin
                    n_fail++; $display("FAIL fill_first_word got addr=%h we=%b wdata=%h exp 0000/1/1234", ram_addr, ram_we, ram_wdata);
                end
            end
            if (fill_done) done_cnt++;
            if (fill_busy) begin
                busy_cycles++;
                if (wr_ready) ready_viol++;
                next_cycle;
            end else begin
                finished = 1;
            end
        end
        n_checks++; if (!finished) begin n_fail++; $display("FAIL fill_timeout got busy after %0d cycles exp idle", busy_cycles); end
        n_checks++; if (busy_cycles != 16384) begin n_fail++; $display("FAIL fill_busy_cycles got %0d exp 16384", busy_cycles); end
        n_checks++; if (ready_viol != 0) begin n_fail++; $display("FAIL fill_wr_ready got %0d ready cycles exp 0", ready_viol); end
        next_cycle;
        wr_valid = 0;
        settle;
        if (fill_done) done_cnt++;
        n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL fill_done_pulses got %0d exp 1", done_cnt); end
        for (int k = 0; k < 4; k++) begin
            disp_read(rr[k], cc[k], d, v);
            n_checks++; if (v !== 1'b1 || d !== 16'h1234) begin
                n_fail++; $display("FAIL fill_readback_%0d_%0d got v=%b rgb=%h exp 1/1234", rr[k], cc[k], v, d);
            end
        end
    endtask

    task automatic test_fill_interleave;
        int         busy_cycles, done_cnt, valid_err, rgb_err, n_req, sb_err, first_bad;
        logic [1:0] hist;
        logic       stop_req, finished;
        logic [13:0] a;
        busy_cycles = 0; done_cnt = 0; valid_err = 0; rgb_err = 0; n_req = 0;
        sb_err = 0; first_bad = -1;
        hist = 2'b00; stop_req = 0; finished = 0;
        next_cycle;
        fill_start = 1; fill_color = 16'h0A0A;
        next_cycle;
        fill_start = 0;
        for (int j = 1; j < 40000 && !finished; j++) begin
            if (!fill_busy) stop_req = 1;
            else busy_cycles++;
            disp_req = !stop_req && (j >= 2) && (j % 2 == 0);
            a = 14'(((j - 2) / 2) >> 1);
            disp_row = a[13:7]; disp_col = a[6:0];
            if (disp_req) n_req++;
            settle;
            if (fill_done) done_cnt++;
            if (disp_valid !== hist[1]) valid_err++;
            if (disp_valid === 1'b1 && disp_rgb !== 16'h0A0A) rgb_err++;
            hist = {hist[0], disp_req};
            if (stop_req && hist == 2'b00) finished = 1;
            else next_cycle;
        end
        n_checks++; if (!finished) begin n_fail++; $display("FAIL mix_timeout got busy after %0d cycles exp idle", busy_cycles); end
        n_checks++; if (busy_cycles < 32767 || busy_cycles > 32769) begin
            n_fail++; $display("FAIL mix_fill_cycles got %0d exp 32767..32769", busy_cycles);
        end
        n_checks++; if (valid_err != 0 || n_req < 16000) begin
            n_fail++; $display("FAIL mix_disp_valid got %0d errors over %0d requests exp 0 over >=16000", valid_err, n_req);
        end
        n_checks++; if (rgb_err != 0) begin n_fail++; $display("FAIL mix_disp_rgb got %0d bad pixels exp 0", rgb_err); end
        n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL mix_fill_done got %0d pulses exp 1", done_cnt); end
        for (int i = 0; i < 16386; i++) begin
            next_cycle;
            disp_req = (i < 16384);
            a = 14'(i);
            disp_row = a[13:7]; disp_col = a[6:0];
            settle;
            if (i >= 2 && (disp_valid !== 1'b1 || disp_rgb !== 16'h0A0A)) begin
                sb_err++;
                if (first_bad < 0) first_bad = i - 2;
            end
        end
        disp_req = 0;
        n_checks++; if (sb_err != 0) begin
            n_fail++; $display("FAIL mix_scoreboard got %0d bad words (first addr %0d) exp 0 bad of 16384", sb_err, first_bad);
        end
    endtask

    task automatic test_reset_mid_fill;
        int done_cnt;
        done_cnt = 0;
        next_cycle;
        fill_start = 1; fill_color = 16'h5A5A;
        next_cycle;
        fill_start = 0;
        repeat (100) next_cycle;
        settle;
        n_checks++; if (ram_addr !== 14'd100 || fill_busy !== 1'b1) begin
            n_fail++; $display("FAIL abort_at_100 got addr=%0d busy=%b exp 100/1", ram_addr, fill_busy);
        end
        reset = 1;
        next_cycle;
        settle;
        n_checks++; if (fill_busy !== 1'b0 || ram_we !== 1'b0) begin
            n_fail++; $display("FAIL abort_busy_drop got busy=%b we=%b exp 0/0", fill_busy, ram_we);
        end
        reset = 0;
        for (int i = 0; i < 20; i++) begin
            next_cycle;
            settle;
            if (fill_done) done_cnt++;
        end
        n_checks++; if (done_cnt != 0) begin n_fail++; $display("FAIL abort_no_done got %0d pulses exp 0", done_cnt); end
        next_cycle;
        fill_start = 1; fill_color = 16'h00FF;
        next_cycle;
        fill_start = 0; fill_color = 16'h0000;
        settle;
        n_checks++; if (fill_busy !== 1'b1 || ram_addr !== 14'h0 || ram_we !== 1'b1 || ram_wdata !== 16'h00FF) begin
            n_fail++; $display("FAIL refill_start got busy=%b addr=%h we=%b wdata=%h exp 1/0000/1/00ff", fill_busy, ram_addr, ram_we, ram_wdata);
        end
        next_cycle;
        fill_start = 1; fill_color = 16'h7777;
        settle;
        n_checks++; if (ram_addr !== 14'h1) begin n_fail++; $display("FAIL refill_step got addr=%h exp 0001", ram_addr); end
        next_cycle;
        fill_start = 0;
        settle;
        n_checks++; if (fill_busy !== 1'b1 || ram_addr !== 14'h2 || ram_wdata !== 16'h00FF) begin
            n_fail++; $display("FAIL refill_ignore_start got busy=%b addr=%h wdata=%h exp 1/0002/00ff", fill_busy, ram_addr, ram_wdata);
        end
        reset = 1;
        repeat (2) next_cycle;
        reset = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got no completion exp finish before 2 ms");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_display_pipeline();
        test_writer();
        test_back_to_back();
        test_fill();
        test_fill_interleave();
        test_reset_mid_fill();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fb_bram_arbiter.md
Name: fb_bram_arbiter

Overview:
- Sole owner of the single-port 128x128x16 RGB556 frame buffer BRAM.
- Shares the BRAM between three requesters: display scan-out reads (highest priority, never stalled), a hardware clear/fill engine, and a pixel writer with a valid/ready handshake.
- Sits between the VGA timing/scan logic and the BRAM instance; drives the BRAM address, write-enable and write-data pins.

Parameters:
- ROW_W, 7, row index width (128 rows)
- COL_W, 7, column index width (128 columns)
- PIX_W, 16, pixel width (RGB556)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- disp_req  in  1  display read request this cycle
- disp_row  in  ROW_W  display read row
- disp_col  in  COL_W  display read column
- disp_rgb  out  PIX_W  read pixel, registered
- disp_valid  out  1  disp_rgb holds a new pixel this cycle
- wr_valid  in  1  writer has a pixel
- wr_ready  out  1  writer pixel accepted this cycle
- wr_row  in  ROW_W  write row
- wr_col  in  COL_W  write column
- wr_data  in  PIX_W  write pixel
- fill_start  in  1  one-cycle pulse: fill whole buffer
- fill_color  in  PIX_W  fill colour, sampled on the accepted fill_start
- fill_busy  out  1  fill in progress
- fill_done  out  1  one-cycle pulse when the final fill word is written
- ram_addr  out  ROW_W+COL_W  BRAM address, combinational from the grant mux
- ram_we  out  1  BRAM write enable
- ram_wdata  out  PIX_W  BRAM write data
- ram_rdata  in  PIX_W  BRAM read data, valid one cycle after address

Behaviour:
- Address is {row, col}, i.e. row*128 + col, 14 bits. No multiplier.
- Grant priority each cycle, fixed: display > fill > writer. Exactly one or zero grants per cycle.
- Display grant:
  - ram_addr = {disp_row, disp_col}, ram_we = 0.
  - Request in cycle N → ram_rdata valid in N+1 → disp_rgb registered with disp_valid=1 in N+2. Latency is exactly 2, fully pipelined: back-to-back requests give back-to-back valids.
  - disp_valid is 0 in any cycle whose N-2 had no display request. disp_rgb holds its last value when disp_valid=0.
- Fill FSM, states IDLE and FILL:
  - IDLE→FILL on fill_start: latch fill_color, clear the 14-bit counter to 0, set fill_busy=1 from the next cycle.
  - In FILL, when the display is not requesting: ram_addr = counter, ram_we = 1, ram_wdata = latched colour, counter += 1.
  - When the display requests, the fill stalls and the counter holds.
  - Write at counter 16383 → fill_done=1 in the following cycle, fill_busy=0 in that same cycle, return to IDLE.
  - fill_start while busy is ignored: no restart, colour not re-latched.
- Writer:
  - wr_ready = wr_valid & !disp_req & !fill_busy, combinational.
  - Transfer occurs when wr_valid & wr_ready: ram_we=1, ram_addr={wr_row,wr_col}, ram_wdata=wr_data.
  - Writer must hold its row, col and data stable until ready.
  - A writer request in the same cycle as an accepted fill_start is still granted; the fill starts next cycle.
- No grant: ram_we=0, ram_addr=0, ram_wdata=0.
- Reset values: disp_rgb=0, disp_valid=0, fill_busy=0, fill_done=0, counter=0, latched colour=0, FSM=IDLE.
- Reset mid-fill aborts the fill; no fill_done is issued. Reset clears the read pipeline, so no stale disp_valid appears after reset.
- A display read of an address being filled returns pre-fill or post-fill data according to the write order; no bypass.

Test Plan:
- Reset then disp_req for 4 cycles at (0,0),(0,1),(0,2),(0,3) after preload 0x000F/0x000F/0x0F00/0x0F00 → disp_valid high cycles N+2..N+5 with disp_rgb 0x000F,0x000F,0x0F00,0x0F00.
- Writer pushes (5,7)=0xABCD with disp_req idle → wr_ready=1 same cycle, ram_addr=0x287, ram_we=1; subsequent display read of (5,7) returns 0xABCD after 2 cycles.
- Writer wr_valid held while disp_req high for 3 cycles → wr_ready=0 for those 3 cycles, accepted on cycle 4, exactly one write issued.
- fill_start with fill_color=0x1234, no display traffic → fill_busy high for 16384 cycles, fill_done pulse once; reads of addr 0, 8191, 16383 return 0x1234; wr_ready=0 throughout.
- Fill with display requesting every other cycle → fill completes in 32768±1 cycles, display valids uninterrupted and correct, no address skipped (scoreboard all 16384 words).
- Reset asserted at fill counter 100, then a new fill_start with 0x00FF → fill_busy drops the cycle after reset; the new fill starts at addr 0; no fill_done from the aborted fill; fill_start during an active fill is ignored.
